// File: rtl/uart_sram_loader_pkg.sv
// Shared definitions for the UART-to-SRAM boot loader: FSM encoding,
// parameter defaults and the byte-lane index width.
package uart_sram_loader_pkg;

  localparam int WORD_NUM_DEF  = 256;
  localparam int ADDR_W_DEF    = 19;
  localparam int WR_CYCLES_DEF = 2;
  localparam int LANE_W        = 2;

  localparam logic [1:0] LOAD_IDLE = 2'd0;
  localparam logic [1:0] LOAD_WR   = 2'd1;
  localparam logic [1:0] LOAD_NEXT = 2'd2;
  localparam logic [1:0] CPU_OWN   = 2'd3;

endpackage

// File: rtl/uart_word_packer.sv
// Packs received bytes little-endian into 32-bit words and hands each completed
// word to a single-entry write buffer; a word completing while the buffer is full is lost.
module uart_word_packer
  import uart_sram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        enable_i,
  input  logic        clear_pending_i,
  output logic [31:0] word_o,
  output logic        pending_o,
  output logic        overrun_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    lane_d    = lane_q;
    shift_d   = shift_q;
    word_d    = word_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clear_pending_i) pending_d = 1'b0;
    if (rx_valid_i && enable_i) begin
      case (lane_q)
        2'd0: shift_d[7:0]   = rx_data_i;
        2'd1: shift_d[15:8]  = rx_data_i;
        2'd2: shift_d[23:16] = rx_data_i;
        default: begin
          // The buffer still holds the previous word: drop the new one.
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            word_d    = {rx_data_i, shift_q};
            pending_d = 1'b1;
          end
        end
      endcase
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_q    <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_o    = word_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_sram_loader.sv
// Loads WORD_NUM words from the UART byte stream into SRAM, then hands the SRAM
// port to the CPU. All SRAM pins and CPU handshake outputs are registered.
module uart_sram_loader
  import uart_sram_loader_pkg::*;
#(
  parameter int WORD_NUM  = WORD_NUM_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              load_done,
  output logic              overrun_err
);

  localparam logic [3:0]      WR_LAST  = 4'(WR_CYCLES - 1);
  localparam logic [ADDR_W:0] WORD_END = (ADDR_W + 1)'(WORD_NUM);

  logic [1:0]        state_q, state_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic              acc_q, acc_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [ADDR_W:0]   addr_inc;
  logic              clear_pending, wr_phase;
  logic [31:0]       wbuf;
  logic              pending;

  uart_word_packer u_packer (
    .clk             (clk),
    .reset           (reset),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .enable_i        (state_q != CPU_OWN),
    .clear_pending_i (clear_pending),
    .word_o          (wbuf),
    .pending_o       (pending),
    .overrun_o       (overrun_err)
  );

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    load_addr_d   = load_addr_q;
    acc_d         = 1'b0;
    clear_pending = 1'b0;
    addr_inc      = {1'b0, load_addr_q} + (ADDR_W + 1)'(1);
    case (state_q)
      LOAD_IDLE: begin
        if (pending) begin
          state_d  = LOAD_WR;
          wr_cnt_d = '0;
        end
      end
      LOAD_WR: begin
        wr_cnt_d = wr_cnt_q + 4'd1;
        if (wr_cnt_q == WR_LAST) state_d = LOAD_NEXT;
      end
      LOAD_NEXT: begin
        clear_pending = 1'b1;
        load_addr_d   = addr_inc[ADDR_W-1:0];
        state_d       = (addr_inc == WORD_END) ? CPU_OWN : LOAD_IDLE;
      end
      default: begin
        // No new access during strobe cycle or the cpu_ready cycle.
        acc_d = cpu_req && !acc_q && !cpu_ready_q;
      end
    endcase

    // Strobes are derived from the next state so the pins come straight from flops.
    wr_phase     = (state_d == LOAD_WR);
    ce_n_d       = !(wr_phase || acc_d);
    we_n_d       = !(wr_phase || (acc_d && cpu_we));
    oe_n_d       = !(acc_d && !cpu_we);
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if (wr_phase) begin
      sram_addr_d  = load_addr_q;
      sram_wdata_d = wbuf;
    end else if (acc_d) begin
      sram_addr_d = cpu_addr;
      if (cpu_we) sram_wdata_d = cpu_wdata;
    end

    cpu_ready_d = acc_q;
    cpu_rdata_d = (acc_q && !oe_n_q) ? sram_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LOAD_IDLE;
      wr_cnt_q     <= '0;
      load_addr_q  <= '0;
      acc_q        <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      load_addr_q  <= load_addr_d;
      acc_q        <= acc_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ready  = cpu_ready_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign load_done  = (state_q == CPU_OWN);

endmodule
